// File: rtl/debounce_pkg.sv
// Shared types and constants for the push-button debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW,
    CHK_HIGH,
    IDLE_HIGH,
    CHK_LOW
  } deb_state_t;

  // Sized for STABLE_SAMPLES up to 15.
  localparam int unsigned DEB_CNT_W = 4;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchroniser, tick-driven debounce FSM and
// registered level / press / release outputs. Input is active-high (1 = pressed).
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_SAMPLES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic raw_bit,
  output logic level,
  output logic press,
  output logic release_pulse
);

  localparam logic [DEB_CNT_W-1:0] Target = DEB_CNT_W'(STABLE_SAMPLES);

  logic sync1_q, sync1_d;
  logic in_sync_q, in_sync_d;
  deb_state_t state_q, state_d;
  logic [DEB_CNT_W-1:0] cnt_q, cnt_d;
  logic level_q, level_d;
  logic press_q, press_d;
  logic release_q, release_d;

  // Next-state: the FSM and counter only move on a sampling tick.
  always_comb begin
    sync1_d   = raw_bit;
    in_sync_d = sync1_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    if (tick) begin
      unique case (state_q)
        IDLE_LOW: begin
          if (in_sync_q) begin
            if (STABLE_SAMPLES == 1) begin
              state_d = IDLE_HIGH;
            end else begin
              state_d = CHK_HIGH;
              cnt_d   = DEB_CNT_W'(1);
            end
          end
        end
        CHK_HIGH: begin
          if (!in_sync_q) begin
            state_d = IDLE_LOW;
            cnt_d   = '0;
          end else if (cnt_q + DEB_CNT_W'(1) == Target) begin
            state_d = IDLE_HIGH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + DEB_CNT_W'(1);
          end
        end
        IDLE_HIGH: begin
          if (!in_sync_q) begin
            if (STABLE_SAMPLES == 1) begin
              state_d = IDLE_LOW;
            end else begin
              state_d = CHK_LOW;
              cnt_d   = DEB_CNT_W'(1);
            end
          end
        end
        CHK_LOW: begin
          if (in_sync_q) begin
            state_d = IDLE_HIGH;
            cnt_d   = '0;
          end else if (cnt_q + DEB_CNT_W'(1) == Target) begin
            state_d = IDLE_LOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + DEB_CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end
      endcase
    end
    level_d   = (state_d == IDLE_HIGH) || (state_d == CHK_LOW);
    // Pulses fire only on an accepted edge of the debounced level, so a
    // rejected bounce returning to its idle state emits nothing.
    press_d   = (state_d == IDLE_HIGH) && !level_q;
    release_d = (state_d == IDLE_LOW) && level_q;
  end

  // State, synchroniser and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      in_sync_q <= 1'b0;
      state_q   <= IDLE_LOW;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      in_sync_q <= in_sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level         = level_q;
  assign press         = press_q;
  assign release_pulse = release_q;

endmodule

// File: rtl/button_debouncer.sv
// Multi-button debouncer: synchronises the slow divider square wave, turns its
// rising edges into one-cycle ticks and feeds one debounce channel per button.
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned N_BUTTONS      = 4,
  parameter int unsigned STABLE_SAMPLES = 3,
  parameter bit          ACTIVE_LOW     = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_clk,
  input  logic [N_BUTTONS-1:0] btn_raw,
  output logic [N_BUTTONS-1:0] btn_level,
  output logic [N_BUTTONS-1:0] btn_press,
  output logic [N_BUTTONS-1:0] btn_release
);

  logic samp_sync1_q, samp_sync1_d;
  logic samp_sync2_q, samp_sync2_d;
  logic samp_prev_q, samp_prev_d;
  logic tick;
  logic [N_BUTTONS-1:0] btn_pressed;

  // Internal polarity: 1 always means pressed.
  assign btn_pressed = btn_raw ^ {N_BUTTONS{ACTIVE_LOW}};

  // Synchroniser and edge-detect next-state for sample_clk.
  always_comb begin
    samp_sync1_d = sample_clk;
    samp_sync2_d = samp_sync1_q;
    samp_prev_d  = samp_sync2_q;
  end

  // sample_clk is treated purely as data in the clk domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      samp_sync1_q <= 1'b0;
      samp_sync2_q <= 1'b0;
      samp_prev_q  <= 1'b0;
    end else begin
      samp_sync1_q <= samp_sync1_d;
      samp_sync2_q <= samp_sync2_d;
      samp_prev_q  <= samp_prev_d;
    end
  end

  assign tick = samp_sync2_q & ~samp_prev_q;

  for (genvar i = 0; i < int'(N_BUTTONS); i++) begin : g_chan
    debounce_channel #(
      .STABLE_SAMPLES(STABLE_SAMPLES)
    ) u_chan (
      .clk          (clk),
      .reset        (reset),
      .tick         (tick),
      .raw_bit      (btn_pressed[i]),
      .level        (btn_level[i]),
      .press        (btn_press[i]),
      .release_pulse(btn_release[i])
    );
  end

endmodule
